// File: rtl/uart_tx_module_pkg.sv
// ============================================================================
// Module   : uart_tx_module_pkg
// Purpose  : Shared UART definitions: state encodings, default line settings
//            and frame constants, common to the transmit and receive paths.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_tx_module_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int unsigned c_def_clk_freq = 50_000_000;
    localparam int unsigned c_def_baud     = 9600;
    localparam logic [2:0]  c_last_idx     = 3'd7;

endpackage

`default_nettype wire

// File: rtl/uart_tx_band_gen.sv
// ============================================================================
// Module   : uart_tx_band_gen
// Purpose  : Bit-period counter; bit_tick marks the last cycle of each bit.
//            Held at zero while disabled so every bit starts a full period.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_band_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_tick
);

    localparam int unsigned   c_cnt_w    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_terminal = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        bit_tick = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == c_terminal) begin
            cnt_d    = '0;
            bit_tick = 1'b1;
        end else begin
            cnt_d = cnt_q + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_module.sv
// ============================================================================
// Module   : uart_tx_module
// Purpose  : UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for an
//            extra parity bit (sense chosen by PARITY_ODD). All outputs registered.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_module
    import uart_tx_module_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = c_def_clk_freq,
    parameter int unsigned BAUD       = c_def_baud,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en_sig,
    input  logic [7:0] tx_data,
    output logic       tx_pin_out,
    output logic       tx_busy,
    output logic       tx_done_sig
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

    generate
        if (CLKS_PER_BIT < 2 || PARITY_ODD > 1) begin : g_cfg_check
            $error("uart_tx_module: CLKS_PER_BIT must be >= 2 and PARITY_ODD must be 0 or 1");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    localparam logic c_parity_odd = (PARITY_ODD != 0);
`endif

    tx_state_e  state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       pin_q, pin_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       w_bit_tick;
    logic       w_count_en;

    assign w_count_en = (state_q != ST_IDLE);

    uart_tx_band_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_band_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (w_count_en),
        .bit_tick (w_bit_tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
        pin_d   = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (tx_en_sig) begin
                    data_d  = tx_data;
                    idx_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    if (idx_q == c_last_idx) begin
                        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_bit_tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level is decoded from the next state so the pin is a plain flop.
        case (state_d)
            ST_START:  pin_d = 1'b0;
            ST_DATA:   pin_d = data_d[idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: pin_d = ^data_d ^ c_parity_odd;
`endif
            default:   pin_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            pin_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            pin_q   <= pin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_pin_out  = pin_q;
    assign tx_busy     = busy_q;
    assign tx_done_sig = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_module.sv
// ============================================================================
// Module   : tb_uart_tx_module
// Purpose  : Self-checking bench for uart_tx_module against a frame model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_module;

    localparam int unsigned CLK_FREQ   = 16;
    localparam int unsigned BAUD       = 1;
    localparam int          CPB        = 16;
    localparam int unsigned PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS      = 11;
    localparam bit HAS_PARITY = 1'b1;
`else
    localparam int NBITS      = 10;
    localparam bit HAS_PARITY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en_sig;
    logic [7:0] tx_data;
    logic       tx_pin_out;
    logic       tx_busy;
    logic       tx_done_sig;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    uart_tx_module #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_en_sig   (tx_en_sig),
        .tx_data     (tx_data),
        .tx_pin_out  (tx_pin_out),
        .tx_busy     (tx_busy),
        .tx_done_sig (tx_done_sig)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame bit k of byte d: start, D0..D7, optional parity, stop.
    function automatic logic expected_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (HAS_PARITY && k == 9) return logic'(($countones(d) % 2 == 1) ^ (PARITY_ODD != 0));
        return 1'b1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input logic [7:0] d, input bit hold);
        tx_data   = d;
        tx_en_sig = 1'b1;
        tick(1);
        if (!hold) tx_en_sig = 1'b0;
        check_val("start_low", tx_pin_out, 1'b0);
        check_val("busy_set", tx_busy, 1'b1);
    endtask

    // Entered on the first low cycle; returns on the cycle that must carry done.
    task automatic check_frame(input logic [7:0] d, input bit meddle, input bit drop_en);
        int bad_busy   = 0;
        int early_done = 0;
        for (int c = 0; c < NBITS * CPB; c++) begin
            if (c % CPB == CPB / 2)
                check_val($sformatf("bit%0d_of_%02h", c / CPB, d), tx_pin_out, expected_bit(d, c / CPB));
            if (tx_busy !== 1'b1) bad_busy++;
            if (tx_done_sig !== 1'b0) early_done++;
            if (meddle) begin
                tx_data = 8'($urandom);
                if (c == 40) tx_en_sig = 1'b1;
                if (c == 41) tx_en_sig = 1'b0;
            end
            if (drop_en && c == CPB) tx_en_sig = 1'b0;
            tick(1);
        end
        check_val("busy_in_frame", bad_busy, 0);
        check_val("no_early_done", early_done, 0);
        check_val("done_pulse", tx_done_sig, 1'b1);
        check_val("busy_clear", tx_busy, 1'b0);
        check_val("line_idle_at_done", tx_pin_out, 1'b1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          activity;
        int unsigned t0;
        logic [7:0]  d;

        rst       = 1'b1;
        tx_en_sig = 1'b0;
        tx_data   = 8'h00;
        tick(3);
        check_val("rst_pin", tx_pin_out, 1'b1);
        check_val("rst_busy", tx_busy, 1'b0);
        check_val("rst_done", tx_done_sig, 1'b0);
        rst = 1'b0;

        activity = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (tx_pin_out !== 1'b1 || tx_busy !== 1'b0 || tx_done_sig !== 1'b0) activity++;
        end
        check_val("idle_quiet", activity, 0);

        start_frame(8'h55, 1'b0);
        check_frame(8'h55, 1'b0, 1'b0);
        tick(1);
        check_val("done_single_55", tx_done_sig, 1'b0);

        start_frame(8'hA3, 1'b0);
        check_frame(8'hA3, 1'b1, 1'b0);
        tick(1);
        check_val("done_single_a3", tx_done_sig, 1'b0);
        check_val("no_restart_a3", tx_pin_out, 1'b1);

        // Held request: second frame must start on the cycle after done.
        start_frame(8'h0F, 1'b1);
        t0      = cyc;
        tx_data = 8'hF0;
        check_frame(8'h0F, 1'b0, 1'b0);
        tick(1);
        check_val("b2b_start_low", tx_pin_out, 1'b0);
        check_val("b2b_done_drop", tx_done_sig, 1'b0);
        check_val("b2b_busy", tx_busy, 1'b1);
        check_frame(8'hF0, 1'b0, 1'b1);
        check_val("b2b_total_cycles", cyc - t0, 2 * NBITS * CPB + 1);
        tick(1);
        check_val("b2b_done_single", tx_done_sig, 1'b0);

        // Reset mid-frame aborts with no completion pulse.
        start_frame(8'h00, 1'b0);
        tick(70);
        rst = 1'b1;
        tick(1);
        check_val("abort_pin", tx_pin_out, 1'b1);
        check_val("abort_busy", tx_busy, 1'b0);
        check_val("abort_done", tx_done_sig, 1'b0);
        rst = 1'b0;
        activity = 0;
        for (int i = 0; i < 2 * NBITS * CPB; i++) begin
            tick(1);
            if (tx_pin_out !== 1'b1 || tx_busy !== 1'b0 || tx_done_sig !== 1'b0) activity++;
        end
        check_val("abort_quiet", activity, 0);

        for (int n = 0; n < 6; n++) begin
            tick(int'($urandom_range(0, 5)));
            d = 8'($urandom);
            start_frame(d, 1'b0);
            check_frame(d, bit'($urandom_range(0, 1)), 1'b0);
            tick(1);
            check_val("rand_done_single", tx_done_sig, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
